// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, data first.
// Optional build macro MEM_TIMEOUT_EN adds a BUSY watchdog with NOP/zero abort and sticky err_o.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_valid_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_valid_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          stall_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          d_grant, i_grant;
  logic          timeout_hit;

  // A requester whose valid is showing this cycle must not be re-granted.
  assign d_grant = d_req_i & ~d_valid_q;
  assign i_grant = if_req_i & ~if_valid_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [DW-1:0] NOP     = DW'(32'h0000_0013);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout_hit = (state_q != IDLE) && !mem_ready_i && (cnt_q == TO_LAST);
  assign err_o       = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
        if (d_grant) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
        end else if (i_grant) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_rdata_d = mem_rdata_i;
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata_i;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
          err_d     = 1'b1;
          if (state_q == BUSY_I) begin
            if_rdata_d = NOP;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign d_valid_o   = d_valid_q;
  // Combinational so the core freezes in the same cycle the request appears.
  assign stall_o     = (if_req_i & ~if_valid_q) | (d_req_i & ~d_valid_q);

endmodule
